npu_result_drain_arb: RTL

//  Drains the 8 pe_result_cache lanes onto one shared write-back stream after a compute pass.

---
 rtl/npu_result_drain_arb_pkg.sv | 19 +
 rtl/npu_result_drain_arb_if.sv | 18 +
 rtl/npu_result_drain_arb_skid_fifo.sv | 43 ++++
 rtl/npu_result_drain_arb.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/npu_result_drain_arb_pkg.sv
// Shared constants and drain FSM encoding for the result-cache drain arbiter.
package npu_result_drain_arb_pkg;

   localparam int NPU_NUM_LANES = 8;
   localparam int NPU_LANE_W    = $clog2(NPU_NUM_LANES);

   typedef enum logic [3:0] {
      DRAIN_IDLE = 4'b0001,
      DRAIN_ARB  = 4'b0010,
      DRAIN_READ = 4'b0100,
      DRAIN_DONE = 4'b1000
   } drain_state_e;

   // Lane-id width that stays legal for a single-lane build.
   function automatic int lane_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/npu_result_drain_arb_if.sv
// Write-back stream (valid/ready) carrying result words tagged with source lane and burst end.
interface npu_result_drain_arb_if
   import npu_result_drain_arb_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LANE_W = NPU_LANE_W
) ();

   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic [LANE_W-1:0] m_lane;
   logic              m_last;

   modport master (output m_valid, m_data, m_lane, m_last, input m_ready);
   modport slave  (input m_valid, m_data, m_lane, m_last, output m_ready);

endinterface

// File: rtl/npu_result_drain_arb_skid_fifo.sv
// Two-entry FIFO for returned result words; exposes occupancy and pop for read-credit math.
module npu_skid_fifo #(
   parameter int W = 36
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] wdata_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] rdata_o,
   output logic         pop_o,
   output logic [1:0]   occ_o
);

   logic [W-1:0] mem_q [2];
   logic         wr_ptr_q;
   logic         rd_ptr_q;
   logic [1:0]   occ_q;

   assign valid_o = (occ_q != 2'd0);
   assign pop_o   = valid_o & ready_i;
   assign rdata_o = mem_q[rd_ptr_q];
   assign occ_o   = occ_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop_o) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         occ_q <= occ_q + {1'b0, push_i} - {1'b0, pop_o};
      end
   end

endmodule

// File: rtl/npu_result_drain_arb.sv
// Round-robin drain of the result-cache lanes onto one write-back stream.
// Optional NPU_DRAIN_PERF_EN adds a saturating stall_cnt output.
module npu_result_drain_arb
   import npu_result_drain_arb_pkg::*;
#(
   parameter int NUM_LANES = NPU_NUM_LANES,
   parameter int DATA_W    = 32,
   parameter int BURST_LEN = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        save_sop,
   output logic [NUM_LANES-1:0]        lane_rd_en,
   input  logic [NUM_LANES*DATA_W-1:0] lane_rd_data,
   output logic [NUM_LANES-1:0]        rd_eop,
   npu_result_drain_arb_if.master      m,
   output logic                        busy,
   output logic                        done
`ifdef NPU_DRAIN_PERF_EN
   ,
   output logic [15:0]                 stall_cnt
`endif
);

   localparam int LW = lane_w(NUM_LANES);
   localparam int CW = $clog2(BURST_LEN) + 1;
   localparam int FW = LW + 1 + DATA_W;

   drain_state_e         state_q;
   logic [NUM_LANES-1:0] pending_q;
   logic [LW-1:0]        rr_ptr_q;
   logic [LW-1:0]        grant_q;
   logic [CW-1:0]        beat_cnt_q;
   logic [CW-1:0]        issued_q;
   logic                 inflight_q;
   logic [NUM_LANES-1:0] rd_eop_q;

   logic [NUM_LANES-1:0] grant_oh;
   logic [NUM_LANES-1:0] pending_left;
   logic [LW-1:0]        pick;
   logic [LW-1:0]        cand;
   logic                 pick_found;

   logic                 fifo_valid;
   logic                 fifo_pop;
   logic [1:0]           fifo_occ;
   logic [FW-1:0]        fifo_wdata;
   logic [FW-1:0]        fifo_rdata;
   logic [LW-1:0]        head_lane;
   logic                 head_last;
   logic [DATA_W-1:0]    head_data;

   logic [2:0]           credit_sum;
   logic                 credit_ok;
   logic                 issue;
   logic                 last_hs;

   always_comb begin
      grant_oh = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         grant_oh[i] = (grant_q == LW'(i));
      end
   end

   assign pending_left = pending_q & ~grant_oh;

   always_comb begin
      pick       = '0;
      cand       = '0;
      pick_found = 1'b0;
      for (int unsigned off = 0; off < NUM_LANES; off++) begin
         cand = LW'((32'(rr_ptr_q) + off) % 32'(NUM_LANES));
         if (!pick_found && pending_q[cand]) begin
            pick       = cand;
            pick_found = 1'b1;
         end
      end
   end

   // A read issued now lands one cycle later, so FIFO slots must be free after this cycle's pop.
   assign credit_sum = {1'b0, fifo_occ} + {2'b00, inflight_q};
   assign credit_ok  = credit_sum < (3'd2 + {2'b00, fifo_pop});
   assign issue      = (state_q == DRAIN_READ) && (issued_q < CW'(BURST_LEN)) && credit_ok;
   assign lane_rd_en = {NUM_LANES{issue}} & grant_oh;

   assign fifo_wdata = {grant_q, (beat_cnt_q == CW'(BURST_LEN - 1)),
                        lane_rd_data[32'(grant_q) * DATA_W +: DATA_W]};

   npu_skid_fifo #(.W(FW)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (inflight_q),
      .wdata_i (fifo_wdata),
      .ready_i (m.m_ready),
      .valid_o (fifo_valid),
      .rdata_o (fifo_rdata),
      .pop_o   (fifo_pop),
      .occ_o   (fifo_occ)
   );

   assign {head_lane, head_last, head_data} = fifo_rdata;
   assign last_hs   = fifo_pop & head_last;

   assign m.m_valid = fifo_valid;
   assign m.m_data  = head_data & {DATA_W{fifo_valid}};
   assign m.m_lane  = head_lane & {LW{fifo_valid}};
   assign m.m_last  = head_last & fifo_valid;

   assign rd_eop = rd_eop_q;
   assign busy   = (state_q != DRAIN_IDLE);
   assign done   = (state_q == DRAIN_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= DRAIN_IDLE;
         pending_q  <= '0;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         beat_cnt_q <= '0;
         issued_q   <= '0;
         inflight_q <= 1'b0;
         rd_eop_q   <= '0;
      end else begin
         rd_eop_q   <= '0;
         inflight_q <= issue;
         if (inflight_q) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
         end
         if (issue) begin
            issued_q <= issued_q + 1'b1;
         end
         case (state_q)
            DRAIN_IDLE: begin
               if (save_sop) begin
                  pending_q <= '1;
                  state_q   <= DRAIN_ARB;
               end
            end
            DRAIN_ARB: begin
               grant_q    <= pick;
               beat_cnt_q <= '0;
               issued_q   <= '0;
               state_q    <= DRAIN_READ;
            end
            DRAIN_READ: begin
               if (last_hs) begin
                  pending_q <= pending_left;
                  rd_eop_q  <= grant_oh;
                  rr_ptr_q  <= (grant_q == LW'(NUM_LANES - 1)) ? '0 : grant_q + 1'b1;
                  state_q   <= (pending_left != '0) ? DRAIN_ARB : DRAIN_DONE;
               end
            end
            DRAIN_DONE: state_q <= DRAIN_IDLE;
            default:    state_q <= DRAIN_IDLE;
         endcase
      end
   end

`ifdef NPU_DRAIN_PERF_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
      end else if ((state_q == DRAIN_IDLE) && save_sop) begin
         stall_cnt_q <= '0;
      end else if (busy && fifo_valid && !m.m_ready && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule
